// File: rtl/uart_image_rx.sv
// UART image loader: receives 8N1 bytes (8E1 when RX_PARITY_EN is defined), packs BPP bytes
// per pixel and writes HIEGHT*WIDTH pixels in raster order, then raises done.
module uart_image_rx #(
  parameter int BPP           = 3,
  parameter int HIEGHT        = 30,
  parameter int WIDTH         = 30,
  parameter int TICK_PER_HALF = 1302,
  localparam int NPIX  = HIEGHT * WIDTH,
  localparam int AW    = (NPIX > 1) ? $clog2(NPIX) : 1,
  localparam int PIX_W = 8 * BPP,
  localparam int BW    = (BPP > 1) ? $clog2(BPP) : 1,
  localparam int CW    = $clog2(2 * TICK_PER_HALF) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             start,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic             rx_active,
  output logic             frame_err,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [CW-1:0] HALF_LAST = CW'(TICK_PER_HALF - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(2 * TICK_PER_HALF - 1);

  state_t             state_q, state_d;
  logic               rx_s1_q, rx_s1_d;
  logic               rx_s2_q, rx_s2_d;
  logic               rx_prev_q, rx_prev_d;
  logic               start_prev_q, start_prev_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         sh_q, sh_d;
  logic               par_bad_q, par_bad_d;
  logic [BW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [AW-1:0]      pix_idx_q, pix_idx_d;
  logic               armed_q, armed_d;
  logic               wr_en_q, wr_en_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]   wr_data_q, wr_data_d;
  logic               rx_active_q, rx_active_d;
  logic               frame_err_q, frame_err_d;
  logic               done_q, done_d;

  logic               rx_fall;
  logic               start_rise;
  logic [PIX_W-1:0]   pix_next;

  assign rx_fall    = rx_prev_q & ~rx_s2_q;
  assign start_rise = start & ~start_prev_q;
  assign pix_next   = (pix_q << 8) | PIX_W'(sh_q);

  always_comb begin
    state_d      = state_q;
    rx_s1_d      = rx;
    rx_s2_d      = rx_s1_q;
    rx_prev_d    = rx_s2_q;
    start_prev_d = start;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    sh_d         = sh_q;
    par_bad_d    = par_bad_q;
    byte_cnt_d   = byte_cnt_q;
    pix_d        = pix_q;
    pix_idx_d    = pix_idx_q;
    armed_d      = armed_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rx_active_d  = rx_active_q;
    frame_err_d  = 1'b0;
    done_d       = done_q;

    // done follows the final strobe by one cycle; a re-arm below overrides it
    if (wr_en_q && (wr_addr_q == AW'(NPIX - 1))) done_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          armed_d    = 1'b1;
          done_d     = 1'b0;
          pix_idx_d  = '0;
          byte_cnt_d = '0;
        end else if (armed_q && !done_q && rx_fall) begin
          state_d     = S_START;
          cnt_d       = '0;
          par_bad_d   = 1'b0;
          rx_active_d = 1'b1;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s2_q) begin
            state_d     = S_IDLE;
            rx_active_d = 1'b0;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          sh_d      = {rx_s2_q, sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d     = '0;
          par_bad_d = ^{sh_q, rx_s2_q};
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d       = '0;
          state_d     = S_IDLE;
          rx_active_d = 1'b0;
          if (!rx_s2_q || par_bad_q) begin
            frame_err_d = 1'b1;
          end else begin
            pix_d = pix_next;
            if (byte_cnt_q == BW'(BPP - 1)) begin
              byte_cnt_d = '0;
              wr_en_d    = 1'b1;
              wr_addr_d  = pix_idx_q;
              wr_data_d  = pix_next;
              pix_idx_d  = pix_idx_q + 1'b1;
              if (pix_idx_q == AW'(NPIX - 1)) armed_d = 1'b0;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      start_prev_q <= 1'b0;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      par_bad_q    <= 1'b0;
      byte_cnt_q   <= '0;
      pix_q        <= '0;
      pix_idx_q    <= '0;
      armed_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rx_active_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_prev_q    <= rx_prev_d;
      start_prev_q <= start_prev_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sh_q         <= sh_d;
      par_bad_q    <= par_bad_d;
      byte_cnt_q   <= byte_cnt_d;
      pix_q        <= pix_d;
      pix_idx_q    <= pix_idx_d;
      armed_q      <= armed_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rx_active_q  <= rx_active_d;
      frame_err_q  <= frame_err_d;
      done_q       <= done_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rx_active = rx_active_q;
  assign frame_err = frame_err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_uart_image_rx.sv
// Scoreboard bench for uart_image_rx with a 2x2 image of 3-byte pixels and 4 clocks per half bit.
module tb_uart_image_rx;
  localparam int T    = 4;
  localparam int H    = 2;
  localparam int W    = 2;
  localparam int BPP  = 3;
  localparam int NPIX = H * W;
  localparam int AW   = 2;
  localparam int PW   = 8 * BPP;
  localparam int BIT  = 2 * T;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx = 1'b1;
  logic          start = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          rx_active;
  logic          frame_err;
  logic          done;

  uart_image_rx #(.BPP(BPP), .HIEGHT(H), .WIDTH(W), .TICK_PER_HALF(T)) dut (
    .clk(clk), .rst(rst), .rx(rx), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rx_active(rx_active), .frame_err(frame_err), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_seen = 0;
  int   fe_seen = 0;
  int   act_done = 0;
  logic fe_prev = 1'b0;
  logic last_wr = 1'b0;
  logic act_seen = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (last_wr) check("done_after_last_wr", 64'(done), 64'd1);
    last_wr = 1'b0;
    if (wr_en) begin
      wr_seen++;
      check("done_at_wr", 64'(done), 64'd0);
      if (exp_q.size() == 0) begin
        check("sb_size_at_wr", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
      if (wr_addr == AW'(NPIX - 1)) last_wr = 1'b1;
    end
    if (frame_err) begin
      fe_seen++;
      check("fe_pulse_width", 64'(fe_prev), 64'd0);
    end
    fe_prev = frame_err;
    if (rx_active) act_seen = 1'b1;
    if (rx_active && done) act_done++;
  end

  task automatic wait_bit();
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_b, input logic par_flip,
                           input int gap);
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_bit();
    end
`ifdef RX_PARITY_EN
    rx = (^b) ^ par_flip;
    wait_bit();
`endif
    rx = stop_b;
    wait_bit();
    rx = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic arm();
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, fe0;
    logic [7:0] bytes [12];

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_rx_active", 64'(rx_active), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single pixel
    arm();
    exp_q.push_back('{addr: 2'd0, data: 24'h112233});
    send_byte(8'h11, 1'b1, 1'b0, 3);
    send_byte(8'h22, 1'b1, 1'b0, 3);
    send_byte(8'h33, 1'b1, 1'b0, 20);
    check("t1_writes", 64'(wr_seen), 64'd1);
    check("t1_done", 64'(done), 64'd0);

    // Full frame back-to-back, then an ignored 13th byte
    arm();
    for (int k = 0; k < 12; k++) bytes[k] = 8'(k * 17 + 3);
    for (int p = 0; p < NPIX; p++)
      exp_q.push_back('{addr: AW'(p), data: {bytes[3*p], bytes[3*p+1], bytes[3*p+2]}});
    for (int k = 0; k < 12; k++) send_byte(bytes[k], 1'b1, 1'b0, 0);
    wr0 = wr_seen;
    send_byte(8'hEE, 1'b1, 1'b0, 20);
    check("t2_writes", 64'(wr_seen), 64'd5);
    check("t2_13th_ignored", 64'(wr_seen), 64'(wr0));
    check("t2_done_held", 64'(done), 64'd1);
    check("t2_active_while_done", 64'(act_done), 64'd0);

    // Bad stop bit discards the byte
    arm();
    check("t3_done_cleared", 64'(done), 64'd0);
    fe0 = fe_seen;
    wr0 = wr_seen;
    send_byte(8'h55, 1'b0, 1'b0, 16);
    check("t3_frame_err", 64'(fe_seen), 64'(fe0 + 1));
    check("t3_no_write", 64'(wr_seen), 64'(wr0));
    exp_q.push_back('{addr: 2'd0, data: 24'hAABBCC});
    send_byte(8'hAA, 1'b1, 1'b0, 4);
    send_byte(8'hBB, 1'b1, 1'b0, 4);
    send_byte(8'hCC, 1'b1, 1'b0, 20);
    check("t3_writes", 64'(wr_seen), 64'(wr0 + 1));

    // Short glitch is a false start
    act_seen = 1'b0;
    fe0 = fe_seen;
    wr0 = wr_seen;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t4_active_seen", 64'(act_seen), 64'd1);
    check("t4_active_low", 64'(rx_active), 64'd0);
    check("t4_no_fe", 64'(fe_seen), 64'(fe0));
    check("t4_no_write", 64'(wr_seen), 64'(wr0));

    // Reset during bit 4 of the second byte of a pixel
    wr0 = wr_seen;
    send_byte(8'h01, 1'b1, 1'b0, 4);
    rx = 1'b0;
    wait_bit();
    for (int i = 0; i < 4; i++) begin
      rx = (8'h02 >> i) & 1'b1;
      wait_bit();
    end
    rx = 1'b0;
    repeat (T) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_wr_en", 64'(wr_en), 64'd0);
    check("t5_wr_addr", 64'(wr_addr), 64'd0);
    check("t5_wr_data", 64'(wr_data), 64'd0);
    check("t5_rx_active", 64'(rx_active), 64'd0);
    check("t5_frame_err", 64'(frame_err), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_partial_write", 64'(wr_seen), 64'(wr0));
    arm();
    exp_q.push_back('{addr: 2'd0, data: 24'h445566});
    send_byte(8'h44, 1'b1, 1'b0, 2);
    send_byte(8'h55, 1'b1, 1'b0, 2);
    send_byte(8'h66, 1'b1, 1'b0, 20);
    check("t5_writes", 64'(wr_seen), 64'(wr0 + 1));

`ifdef RX_PARITY_EN
    // Even parity: wrong parity bit discards, correct one accepts
    arm();
    fe0 = fe_seen;
    wr0 = wr_seen;
    send_byte(8'h07, 1'b1, 1'b1, 16);
    check("t6_parity_err", 64'(fe_seen), 64'(fe0 + 1));
    exp_q.push_back('{addr: 2'd0, data: 24'h070707});
    for (int k = 0; k < 3; k++) send_byte(8'h07, 1'b1, 1'b0, 4);
    repeat (20) @(posedge clk);
    #1;
    check("t6_writes", 64'(wr_seen), 64'(wr0 + 1));
    check("t6_no_extra_fe", 64'(fe_seen), 64'(fe0 + 1));
`endif

    repeat (20) @(posedge clk);
    #1;
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_image_rx.md
# uart_image_rx

Serial image loader that receives a raw pixel stream over UART (8 data bits, LSB first, one stop bit) and writes whole pixels into the image buffer ahead of the processing core. It runs at the same half-bit tick rate as the design's UART transmitter, so a host can load an image over one wire and read the processed result back over the other. One armed frame is exactly HIEGHT*WIDTH pixels of BPP bytes each; `done` flags that the buffer is full.

## Interface
Parameters:
- BPP, 3, bytes per pixel
- HIEGHT, 30, image rows
- WIDTH, 30, image columns
- TICK_PER_HALF, 1302, clk cycles per half bit period (Fsys/(2*baudrate)); one bit = 2*TICK_PER_HALF cycles

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-low reset
- rx  in  1  UART serial input, idle high, asynchronous to clk
- start  in  1  arm receiver for one frame (level-sampled, acts on rising edge of start)
- wr_en  out  1  one-cycle pixel write strobe
- wr_addr  out  clog2(HIEGHT*WIDTH)  pixel address, 0 .. HIEGHT*WIDTH-1, raster order
- wr_data  out  8*BPP  assembled pixel
- rx_active  out  1  high from start-bit detect to end of stop-bit sample
- frame_err  out  1  one-cycle pulse on bad stop bit (or bad parity when enabled)
- done  out  1  frame complete, held until next arming

## Operation
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Bit FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: only when armed and not done; falling edge of synced rx -> START, tick counter cleared.
- START: at TICK_PER_HALF cycles sample rx; 1 = false start -> IDLE, no error; 0 -> DATA.
- DATA: sample every 2*TICK_PER_HALF cycles, 8 bits, shifted in LSB first.
- STOP: sample after a further 2*TICK_PER_HALF; 1 = byte valid; 0 = frame_err pulse, byte discarded, FSM waits in IDLE for synced rx=1 before hunting a new start.
- Byte assembly: first byte of a pixel lands in wr_data[8*BPP-1 -: 8], last in [7:0]; byte counter 0..BPP-1.
- On the valid byte that completes a pixel: wr_en=1 for one cycle with wr_addr/wr_data valid; then address increments.
- After write at address HIEGHT*WIDTH-1: done=1, receiver disarmed, further rx traffic ignored.
- start rising edge while idle or done: clears done, address and byte counter to 0, arms. start while a byte is in progress: ignored.
- Discarded bytes do not advance the byte counter; the pixel resumes with the next valid byte.

## Timing
- Reset (rst=0 at a clk edge): all outputs 0, FSM IDLE, disarmed, counters 0, synchronizer flops set to 1. Reset mid-byte aborts immediately; no partial write.
- Start-bit sample: TICK_PER_HALF cycles after falling edge seen on synced rx (synchronizer adds 2 cycles of rx latency).
- Data bit i (0..7) sampled at TICK_PER_HALF + 2*TICK_PER_HALF*(i+1); stop at TICK_PER_HALF + 18*TICK_PER_HALF (+2*TICK_PER_HALF with parity).
- wr_en asserts the cycle after the stop sample of a pixel's last byte; done asserts the cycle after the final wr_en.
- rx_active falls on the cycle after the stop sample; IDLE may detect the next start bit on that same cycle (back-to-back bytes, no gap).
- wr_data/wr_addr hold their last value between strobes.

## Configuration
- RX_PARITY_EN defined: frame is 8E1; PARITY state samples a ninth bit; even-parity mismatch pulses frame_err and discards the byte exactly as a bad stop bit does.
- Undefined: 8N1, no PARITY state; frame_err only from stop bit.

## Test plan
(TICK_PER_HALF=4, HIEGHT=WIDTH=2, BPP=3)
- Reset then arm, send bytes 0x11,0x22,0x33 -> wr_en one cycle, wr_addr=0, wr_data=0x112233; done=0.
- Send 12 bytes back-to-back with zero idle gap -> four writes at addresses 0..3, done=1 one cycle after fourth wr_en, 13th byte ignored.
- Byte 0x55 with stop bit driven 0 -> frame_err one-cycle pulse, no byte counted; next valid bytes 0xAA,0xBB,0xCC -> wr_data=0xAABBCC.
- rx low glitch of 3 cycles -> false start, rx_active drops, no frame_err, no write.
- rst=0 during bit 4 of the second byte of a pixel -> all outputs 0; re-arm and send 3 bytes -> write at wr_addr=0.
- With RX_PARITY_EN: 0x07 sent with parity 0 -> frame_err, discarded; with parity 1 -> accepted.
